alu_rs_param: RTL and testbench
===============================

# alu_rs_param

Parametrised reservation station for non-load/store integer instructions. It sits between the decode/rename stage and the ALU, with ROB-facing tags.

- Holds up to DEPTH renamed instructions and captures operands from the CDB.
- Issues the oldest fully-ready entry to the ALU through a valid/ready handshake.
- Supports a full flush on branch mispredict.
- Compared with the fixed 3-entry station, this version adds configurable depth and tag width, age-ordered selection, same-cycle CDB capture at dispatch, issue backpressure and flush.

## Interface
- DEPTH, 4: number of entries (2..8)
- TAG_W, 4: tag width; tag 0 is None
- TAG_BASE, 1: tag of entry 0; entry i owns tag TAG_BASE+i; requires TAG_BASE≥1 and TAG_BASE+DEPTH-1 < 2^TAG_W
- XLEN, 32: data width
- OP_W, 5: opcode width
- clk_in  in  1  single clock; all state updates on the rising edge
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- flush  in  1  mispredict; discard all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry free and rdy_in high and flush low
- disp_tag  out  TAG_W  tag that a dispatch this cycle will receive (lowest free entry); None when full
- disp_op  in  OP_W  ALU op
- disp_vj, disp_vk  in  XLEN  operand values
- disp_qj, disp_qk  in  TAG_W  producer tags, 0 = value valid
- disp_addr  in  XLEN  instruction PC
- cdb_active  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB producer tag
- cdb_val  in  XLEN  CDB value
- iss_valid  out  1  ready entry presented
- iss_ready  in  1  ALU accepts
- iss_tag  out  TAG_W  tag of presented entry
- iss_op  out  OP_W  op of presented entry
- iss_vj, iss_vk, iss_addr  out  XLEN  operands and PC of presented entry
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation

**Entry state**
- Each entry holds busy, op, vj, vk, qj, qk, addr and age (0..DEPTH-1).
- age equals the number of older busy entries.

**Dispatch** (fire = disp_valid && disp_ready)
- Writes the lowest-index free entry with age = count.
- If cdb_active and cdb_tag≠0 and disp_qj==cdb_tag, the entry stores vj=cdb_val, qj=0. The same rule applies independently to qk.

**Wakeup**
- For each busy entry with qj==cdb_tag (cdb_active, tag≠0), set vj=cdb_val and qj=0. Same for qk.
- cdb_tag==0 never matches.

**Select**
- Ready = busy && qj==0 && qk==0.
- iss_* present the ready entry with the smallest age. This is combinational from registered state.
- iss_valid=0 when no entry is ready. iss_* are then 0.

**Issue** (fire = iss_valid && iss_ready)
- The presented entry's busy is cleared.
- Every entry with a greater age decrements its age.
- If the issue fires in the same cycle as a dispatch, the new entry's age = count-1.

**Capacity**
- disp_ready = !full; the dispatch rule above adds the rdy_in/flush qualifiers.
- A slot freed by an issue in a cycle is not reusable until the next cycle.

**Flush**
- All busy bits clear and count goes to 0 on the next edge.
- Dispatch, issue and wakeup in that cycle are discarded.
- disp_ready=0 and iss_valid=0 while flush is high.

**rdy_in low**
- State is held.
- disp_ready=0 and iss_valid=0.
- CDB broadcasts in such cycles are lost; the producer side guarantees none occur.

**count** is the popcount of busy, kept as a register.

## Timing

**Reset** (rst_in high at an edge)
- All entries become non-busy; ages and registers go to 0.
- After reset: count=0, iss_valid=0, iss_* all 0, disp_tag=TAG_BASE, disp_ready=rdy_in.
- Reset mid-operation discards all in-flight entries without issuing them.

**Latencies**
- Dispatch at edge N with both operands valid: iss_valid is high in cycle N+1 at the earliest.
- CDB match during cycle N, at dispatch or in an entry: the entry can issue in cycle N+1.
- iss_* stay stable while iss_valid && !iss_ready, unless an older entry becomes ready. Selection then switches to the older entry. Strict stability is not required.

**Full boundary**
- With DEPTH busy entries, an issue at edge N makes disp_ready high in cycle N+1.

## Test plan
- DEPTH=4, TAG_BASE=1. Reset, then dispatch op ADD with vj=5, vk=7, qj=qk=0 → disp_tag=1; in cycle +1 iss_valid=1, iss_tag=1, iss_vj=5, iss_vk=7. Raise iss_ready → count returns to 0.
- Dispatch A (qj=9) then B (ready) → B issues first. Drive CDB tag 9, val 0x100 → A issues the next cycle with iss_vj=0x100.
- Dispatch with qk=6 in the same cycle as cdb_active, cdb_tag=6, val 0x55 → entry issues the next cycle with iss_vk=0x55.
- Fill 4 entries all waiting on tag 9 → disp_ready=0, disp_tag=0. Broadcast tag 9 → issues go oldest first in tags 1,2,3,4 order with iss_ready held high. disp_ready returns to 1 the cycle after the first issue.
- Hold iss_ready=0 with 3 ready entries → iss_tag fixed at the oldest. Assert flush → next cycle count=0, iss_valid=0. Dispatch after flush gets tag 1.
- rdy_in=0 for 3 cycles with a ready entry and disp_valid=1 → no dispatch, no issue, count unchanged. Assert rst_in with entries busy → count=0, iss_valid=0.

Source files
------------

// File: rtl/alu_rs_param_if.sv
// Dispatch, CDB and issue signals of the ALU reservation station.
// The station itself uses the slave side; the feeding pipeline uses master.
interface alu_rs_param_if #(
    parameter int TAG_W = 4,
    parameter int XLEN  = 32,
    parameter int OP_W  = 5
);
    logic             disp_valid;
    logic             disp_ready;
    logic [TAG_W-1:0] disp_tag;
    logic [OP_W-1:0]  disp_op;
    logic [XLEN-1:0]  disp_vj;
    logic [XLEN-1:0]  disp_vk;
    logic [TAG_W-1:0] disp_qj;
    logic [TAG_W-1:0] disp_qk;
    logic [XLEN-1:0]  disp_addr;
    logic             cdb_active;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_val;
    logic             iss_valid;
    logic             iss_ready;
    logic [TAG_W-1:0] iss_tag;
    logic [OP_W-1:0]  iss_op;
    logic [XLEN-1:0]  iss_vj;
    logic [XLEN-1:0]  iss_vk;
    logic [XLEN-1:0]  iss_addr;

    modport slave (
        input  disp_valid, disp_op, disp_vj, disp_vk, disp_qj, disp_qk, disp_addr,
        input  cdb_active, cdb_tag, cdb_val, iss_ready,
        output disp_ready, disp_tag, iss_valid, iss_tag, iss_op, iss_vj, iss_vk, iss_addr
    );

    modport master (
        output disp_valid, disp_op, disp_vj, disp_vk, disp_qj, disp_qk, disp_addr,
        output cdb_active, cdb_tag, cdb_val, iss_ready,
        input  disp_ready, disp_tag, iss_valid, iss_tag, iss_op, iss_vj, iss_vk, iss_addr
    );
endinterface

// File: rtl/alu_rs_param.sv
// Parametrised ALU reservation station: captures operands from the CDB and
// issues the oldest fully-ready entry; supports flush and a global stall.
module alu_rs_param #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1,
    parameter int XLEN     = 32,
    parameter int OP_W     = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    alu_rs_param_if.slave         rs,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AGE_W = $clog2(DEPTH);
    localparam int CNT_W = AGE_W + 1;
    localparam logic [TAG_W-1:0] TAG_BASE_T = TAG_W'(TAG_BASE);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [OP_W-1:0]  op_q   [DEPTH];
    logic [OP_W-1:0]  op_d   [DEPTH];
    logic [XLEN-1:0]  vj_q   [DEPTH];
    logic [XLEN-1:0]  vj_d   [DEPTH];
    logic [XLEN-1:0]  vk_q   [DEPTH];
    logic [XLEN-1:0]  vk_d   [DEPTH];
    logic [TAG_W-1:0] qj_q   [DEPTH];
    logic [TAG_W-1:0] qj_d   [DEPTH];
    logic [TAG_W-1:0] qk_q   [DEPTH];
    logic [TAG_W-1:0] qk_d   [DEPTH];
    logic [XLEN-1:0]  addr_q [DEPTH];
    logic [XLEN-1:0]  addr_d [DEPTH];
    logic [AGE_W-1:0] age_q  [DEPTH];
    logic [AGE_W-1:0] age_d  [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic             full;
    logic             anyReady;
    logic [AGE_W-1:0] freeIdx;
    logic [AGE_W-1:0] selIdx;
    logic [AGE_W-1:0] selAge;
    logic             issValid;
    logic             dispFire;
    logic             issFire;
    logic             cdbHit;

    // Lowest free slot for dispatch and lowest-age ready slot for issue.
    always_comb begin
        full     = &busy_q;
        freeIdx  = '0;
        anyReady = 1'b0;
        selIdx   = '0;
        selAge   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) freeIdx = AGE_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0 &&
                (!anyReady || age_q[i] < selAge)) begin
                anyReady = 1'b1;
                selIdx   = AGE_W'(i);
                selAge   = age_q[i];
            end
        end
    end

    assign issValid      = anyReady && rdy_in && !flush;
    assign rs.iss_valid  = issValid;
    assign rs.disp_ready = !full && rdy_in && !flush;
    assign rs.disp_tag   = full ? '0 : TAG_BASE_T + TAG_W'(freeIdx);
    assign count         = count_q;

    always_comb begin
        rs.iss_tag  = '0;
        rs.iss_op   = '0;
        rs.iss_vj   = '0;
        rs.iss_vk   = '0;
        rs.iss_addr = '0;
        if (issValid) begin
            rs.iss_tag  = TAG_BASE_T + TAG_W'(selIdx);
            rs.iss_op   = op_q[selIdx];
            rs.iss_vj   = vj_q[selIdx];
            rs.iss_vk   = vk_q[selIdx];
            rs.iss_addr = addr_q[selIdx];
        end
    end

    assign dispFire = rs.disp_valid && rs.disp_ready;
    assign issFire  = issValid && rs.iss_ready;
    assign cdbHit   = rs.cdb_active && rs.cdb_tag != '0;

    // Wakeup, issue and dispatch; a slot freed by issue is not reused this
    // cycle because freeIdx comes from the registered busy bits.
    always_comb begin
        busy_d  = busy_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        addr_d  = addr_q;
        age_d   = age_q;
        count_d = count_q;
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && cdbHit && qj_q[i] == rs.cdb_tag) begin
                    vj_d[i] = rs.cdb_val;
                    qj_d[i] = '0;
                end
                if (busy_q[i] && cdbHit && qk_q[i] == rs.cdb_tag) begin
                    vk_d[i] = rs.cdb_val;
                    qk_d[i] = '0;
                end
                if (issFire && busy_q[i] && age_q[i] > selAge) age_d[i] = age_q[i] - 1'b1;
            end
            if (issFire) busy_d[selIdx] = 1'b0;
            if (dispFire) begin
                busy_d[freeIdx] = 1'b1;
                op_d[freeIdx]   = rs.disp_op;
                addr_d[freeIdx] = rs.disp_addr;
                age_d[freeIdx]  = AGE_W'(count_q - CNT_W'(issFire));
                if (cdbHit && rs.disp_qj == rs.cdb_tag) begin
                    vj_d[freeIdx] = rs.cdb_val;
                    qj_d[freeIdx] = '0;
                end else begin
                    vj_d[freeIdx] = rs.disp_vj;
                    qj_d[freeIdx] = rs.disp_qj;
                end
                if (cdbHit && rs.disp_qk == rs.cdb_tag) begin
                    vk_d[freeIdx] = rs.cdb_val;
                    qk_d[freeIdx] = '0;
                end else begin
                    vk_d[freeIdx] = rs.disp_vk;
                    qk_d[freeIdx] = rs.disp_qk;
                end
            end
            count_d = count_q + CNT_W'(dispFire) - CNT_W'(issFire);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                addr_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            busy_q  <= busy_d;
            count_q <= count_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            addr_q  <= addr_d;
            age_q   <= age_d;
        end
    end
endmodule

// File: tb/tb_alu_rs_param.sv
// Directed bench for alu_rs_param (DEPTH=4, TAG_BASE=1) with an issue scoreboard.
module tb_alu_rs_param;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_SLT = 5'd6;

    typedef struct packed {
        logic [3:0]  tag;
        logic [4:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] addr;
    } issue_t;

    logic       clk;
    logic       rst;
    logic       rdy;
    logic       flush;
    logic [2:0] count;
    int         assertCount = 0;
    int         failCount   = 0;
    issue_t     expQ[$];
    issue_t     monExp;

    alu_rs_param_if #(.TAG_W(4), .XLEN(32), .OP_W(5)) rs ();

    alu_rs_param #(
        .DEPTH(4), .TAG_W(4), .TAG_BASE(1), .XLEN(32), .OP_W(5)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .flush(flush),
        .rs(rs),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                 input logic [3:0] qj, input logic [3:0] qk, input logic [31:0] addr);
        rs.disp_valid = 1'b1;
        rs.disp_op    = op;
        rs.disp_vj    = vj;
        rs.disp_vk    = vk;
        rs.disp_qj    = qj;
        rs.disp_qk    = qk;
        rs.disp_addr  = addr;
    endtask

    task automatic expectIssue(input logic [3:0] tag, input logic [4:0] op, input logic [31:0] vj,
                               input logic [31:0] vk, input logic [31:0] addr);
        expQ.push_back('{tag: tag, op: op, vj: vj, vk: vk, addr: addr});
    endtask

    task automatic cdbSend(input logic [3:0] tag, input logic [31:0] val);
        rs.cdb_active = 1'b1;
        rs.cdb_tag    = tag;
        rs.cdb_val    = val;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Every accepted issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rs.iss_valid && rs.iss_ready) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpectedIssue: got tag %0d, expected no issue", rs.iss_tag);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("issTag",  32'(rs.iss_tag), 32'(monExp.tag));
                checkOutput("issOp",   32'(rs.iss_op),  32'(monExp.op));
                checkOutput("issVj",   rs.iss_vj,       monExp.vj);
                checkOutput("issVk",   rs.iss_vk,       monExp.vk);
                checkOutput("issAddr", rs.iss_addr,     monExp.addr);
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        rs.disp_valid = 1'b0; rs.disp_op = '0; rs.disp_vj = '0; rs.disp_vk = '0;
        rs.disp_qj = '0; rs.disp_qk = '0; rs.disp_addr = '0;
        rs.cdb_active = 1'b0; rs.cdb_tag = '0; rs.cdb_val = '0; rs.iss_ready = 1'b0;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        sample();
        checkOutput("resetCount",     32'(count),         0);
        checkOutput("resetIssValid",  32'(rs.iss_valid),  0);
        checkOutput("resetIssTag",    32'(rs.iss_tag),    0);
        checkOutput("resetIssVj",     rs.iss_vj,          0);
        checkOutput("resetDispTag",   32'(rs.disp_tag),   1);
        checkOutput("resetDispReady", 32'(rs.disp_ready), 1);

        // Single ready ADD issues the cycle after dispatch.
        nextCycle(); applyStimulus(OP_ADD, 5, 7, 4'd0, 4'd0, 32'h1000);
        sample(); checkOutput("addDispTag", 32'(rs.disp_tag), 1);
        nextCycle(); rs.disp_valid = 1'b0; rs.iss_ready = 1'b1;
        expectIssue(4'd1, OP_ADD, 5, 7, 32'h1000);
        sample(); checkOutput("addIssValid", 32'(rs.iss_valid), 1);
        checkOutput("addCount", 32'(count), 1);
        nextCycle(); rs.iss_ready = 1'b0;
        sample(); checkOutput("addCountAfter", 32'(count), 0);
        checkOutput("addIssValidAfter", 32'(rs.iss_valid), 0);

        // Younger ready B overtakes A waiting on tag 9.
        nextCycle(); applyStimulus(OP_SUB, 32'hDEAD, 3, 4'd9, 4'd0, 32'h2000);
        sample(); checkOutput("waitDispTagA", 32'(rs.disp_tag), 1);
        nextCycle(); applyStimulus(OP_OR, 10, 20, 4'd0, 4'd0, 32'h2004);
        sample(); checkOutput("waitDispTagB", 32'(rs.disp_tag), 2);
        checkOutput("waitNotReady", 32'(rs.iss_valid), 0);
        nextCycle(); rs.disp_valid = 1'b0; rs.iss_ready = 1'b1;
        expectIssue(4'd2, OP_OR, 10, 20, 32'h2004);
        sample(); checkOutput("waitCount", 32'(count), 2);
        nextCycle(); rs.iss_ready = 1'b0; cdbSend(4'd9, 32'h100);
        sample(); checkOutput("waitStillBlocked", 32'(rs.iss_valid), 0);
        nextCycle(); rs.cdb_active = 1'b0; rs.iss_ready = 1'b1;
        expectIssue(4'd1, OP_SUB, 32'h100, 3, 32'h2000);
        sample();
        nextCycle(); rs.iss_ready = 1'b0;
        sample(); checkOutput("waitCountAfter", 32'(count), 0);

        // Operand captured from the CDB in the dispatch cycle.
        nextCycle(); applyStimulus(OP_AND, 32'h11, 32'hBEEF, 4'd0, 4'd6, 32'h3000);
        cdbSend(4'd6, 32'h55);
        sample(); checkOutput("bypassNoIssueYet", 32'(rs.iss_valid), 0);
        nextCycle(); rs.disp_valid = 1'b0; rs.cdb_active = 1'b0; rs.iss_ready = 1'b1;
        expectIssue(4'd1, OP_AND, 32'h11, 32'h55, 32'h3000);
        sample(); checkOutput("bypassIssValid", 32'(rs.iss_valid), 1);
        nextCycle(); rs.iss_ready = 1'b0;
        sample(); checkOutput("bypassCountAfter", 32'(count), 0);

        // Fill all four slots, release together, drain oldest first.
        for (int i = 0; i < 4; i++) begin
            nextCycle(); applyStimulus(OP_XOR, 0, 32'(i + 1), 4'd9, 4'd0, 32'h4000 + 32'(4 * i));
            sample(); checkOutput("fillDispTag", 32'(rs.disp_tag), 32'(i + 1));
        end
        nextCycle(); rs.disp_valid = 1'b0;
        sample(); checkOutput("fullDispReady", 32'(rs.disp_ready), 0);
        checkOutput("fullDispTag", 32'(rs.disp_tag), 0);
        checkOutput("fullCount", 32'(count), 4);
        checkOutput("fullIssValid", 32'(rs.iss_valid), 0);
        nextCycle(); cdbSend(4'd9, 32'h900);
        sample();
        nextCycle(); rs.cdb_active = 1'b0; rs.iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) expectIssue(4'(i + 1), OP_XOR, 32'h900, 32'(i + 1), 32'h4000 + 32'(4 * i));
        sample(); checkOutput("fullStillBlocked", 32'(rs.disp_ready), 0);
        nextCycle();
        sample(); checkOutput("freedDispReady", 32'(rs.disp_ready), 1);
        checkOutput("freedDispTag", 32'(rs.disp_tag), 1);
        nextCycle();
        nextCycle();
        nextCycle(); rs.iss_ready = 1'b0;
        sample(); checkOutput("drainCount", 32'(count), 0);

        // Backpressure keeps the oldest presented, then flush discards all.
        for (int i = 0; i < 3; i++) begin
            nextCycle(); applyStimulus(OP_SLT, 32'(i), 32'(2 * i), 4'd0, 4'd0, 32'h5000 + 32'(4 * i));
        end
        nextCycle(); rs.disp_valid = 1'b0;
        sample(); checkOutput("holdIssTag", 32'(rs.iss_tag), 1);
        checkOutput("holdIssValid", 32'(rs.iss_valid), 1);
        checkOutput("holdCount", 32'(count), 3);
        nextCycle();
        sample(); checkOutput("holdIssTagStable", 32'(rs.iss_tag), 1);
        nextCycle(); flush = 1'b1; applyStimulus(OP_ADD, 8, 8, 4'd0, 4'd0, 32'h5100);
        sample(); checkOutput("flushDispReady", 32'(rs.disp_ready), 0);
        checkOutput("flushIssValid", 32'(rs.iss_valid), 0);
        nextCycle(); flush = 1'b0; rs.disp_valid = 1'b0;
        sample(); checkOutput("flushCount", 32'(count), 0);
        checkOutput("flushIssValidAfter", 32'(rs.iss_valid), 0);
        checkOutput("flushDispTag", 32'(rs.disp_tag), 1);
        nextCycle(); applyStimulus(OP_ADD, 1, 2, 4'd0, 4'd0, 32'h6000);
        sample(); checkOutput("postFlushDispTag", 32'(rs.disp_tag), 1);
        nextCycle(); rs.disp_valid = 1'b0; rs.iss_ready = 1'b1;
        expectIssue(4'd1, OP_ADD, 1, 2, 32'h6000);
        sample();

        // Global stall freezes everything; reset drops busy entries.
        nextCycle(); rs.iss_ready = 1'b0; applyStimulus(OP_SUB, 9, 4, 4'd0, 4'd0, 32'h7000);
        sample(); checkOutput("stallDispTag", 32'(rs.disp_tag), 1);
        nextCycle(); rdy = 1'b0; rs.iss_ready = 1'b1;
        applyStimulus(OP_OR, 1, 1, 4'd0, 4'd0, 32'h7004);
        for (int i = 0; i < 3; i++) begin
            sample(); checkOutput("stallIssValid", 32'(rs.iss_valid), 0);
            checkOutput("stallDispReady", 32'(rs.disp_ready), 0);
            checkOutput("stallCount", 32'(count), 1);
            nextCycle();
        end
        rdy = 1'b1; rs.disp_valid = 1'b0; rs.iss_ready = 1'b0;
        sample(); checkOutput("resumeCount", 32'(count), 1);
        checkOutput("resumeIssTag", 32'(rs.iss_tag), 1);
        checkOutput("resumeIssVj", rs.iss_vj, 9);
        nextCycle(); applyStimulus(OP_AND, 3, 3, 4'd0, 4'd0, 32'h7008);
        sample(); checkOutput("resumeDispTag", 32'(rs.disp_tag), 2);
        nextCycle(); rs.disp_valid = 1'b0;
        sample(); checkOutput("preResetCount", 32'(count), 2);
        rst = 1'b1;
        nextCycle(); rst = 1'b0;
        sample(); checkOutput("midResetCount", 32'(count), 0);
        checkOutput("midResetIssValid", 32'(rs.iss_valid), 0);

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
